commit_unit: RTL
================

// Module: commit_unit
// PURPOSE
//  Retire stage on the far side of writeback. Consumes the registered per-slot wb results and commit controls
//  and performs the architectural side effects: regfile write, CSR write, exception/ertn/idle handling.
//  Produces the pipeline flush/redirect and idle pause toward ctrl, plus a retired-instruction counter.
//  Slot 0 is always older than slot 1.
// PARAMETERS
//  ISSUE_WIDTH  2   retire slots per cycle (spec and tests cover 2)
//  REG_AW       5   GPR address width
//  CSR_AW       14  CSR address width
//  ECODE_W      6   exception code width
// PORTS
//  clk             in   1              clock
//  rst             in   1              synchronous, active-high reset
//  wb_valid_i      in   IW             slot holds a real instruction
//  wb_pc_i         in   IW*32          slot PC
//  wb_reg_we_i     in   IW             GPR write request
//  wb_reg_waddr_i  in   IW*REG_AW      GPR write address
//  wb_reg_wdata_i  in   IW*32          GPR write data
//  wb_csr_we_i     in   1              CSR write request (slot 0 only)
//  wb_csr_waddr_i  in   CSR_AW         CSR write address
//  wb_csr_wdata_i  in   32             CSR write data
//  wb_excp_i       in   IW             slot raised an exception
//  wb_ecode_i      in   IW*ECODE_W     exception code
//  wb_ertn_i       in   IW             slot is ERTN
//  wb_idle_i       in   IW             slot is IDLE
//  int_pending_i   in   1              unmasked interrupt pending
//  csr_eentry_i    in   32             exception entry address
//  csr_era_i       in   32             exception return address
//  reg_we_o/reg_waddr_o/reg_wdata_o  out  IW/IW*REG_AW/IW*32  regfile write ports
//  csr_we_o/csr_waddr_o/csr_wdata_o  out  1/CSR_AW/32         CSR write port
//  excp_o          out  1              exception taken (CSR unit saves ERA/ESTAT)
//  excp_ecode_o    out  ECODE_W        code of taken exception (0 = interrupt)
//  excp_pc_o       out  32             PC saved to ERA
//  ertn_o          out  1              ERTN retired
//  flush_o         out  1              one-cycle pipeline flush
//  redirect_pc_o   out  32             fetch target, valid while flush_o
//  pause_o         out  1              stall front end (idle)
//  retire_cnt_o    out  64             count of retired instructions
// BEHAVIOUR
//  - All outputs are registered; latency from sampled inputs to side effects is 1 cycle. On reset, every output is 0 and the FSM is RUN.
//  - Find the first slot k with valid and (excp | ertn | idle). Slots older than k retire. Slot k retires its
//    effect. Slots younger than k are dropped: no reg/csr write and not counted.
//  - An excepting slot writes nothing. ertn/idle slots retire and count.
//  - Interrupt: if int_pending_i and slot0 is valid in RUN, it is treated as an exception on slot0 with ecode 0. It beats a slot0 sync exception.
//  - Exception: excp_o=1, excp_pc_o=slot pc, flush_o=1, redirect_pc_o=csr_eentry_i.
//  - ERTN: ertn_o=1, flush_o=1, redirect_pc_o=csr_era_i.
//  - A CSR write on slot0 with no exception commits. It also forces flush_o with redirect_pc_o=pc0+4.
//  - Writes to r0 are suppressed. If both slots write the same register, the slot0 enable is cleared (younger wins).
//  - FSM RUN->FLUSH on any redirect event. FLUSH lasts 1 cycle, ignores inputs, then ->RUN.
//  - FSM RUN->IDLE on idle retire: pause_o=1 from the next cycle; inputs are ignored.
//  - IDLE->FLUSH when int_pending_i: excp_o=1, ecode 0, excp_pc_o=idle pc+4, redirect_pc_o=csr_eentry_i, pause_o drops in the same cycle.
//  - retire_cnt_o adds the number of retired slots (0..2) each cycle and wraps modulo 2^64.
//  - Reset mid-FLUSH or mid-IDLE goes to RUN with all outputs 0.
// STRUCTURE
//  - pipeline_types package: commit_state_t {RUN, IDLE, FLUSH}, ECODE_INT = 0, and a commit_req_t per-slot struct matching the wb/commit_ctrl fields.
//  - One sub-module, commit_slot_select: combinational first-event priority encoder producing retire mask, event slot and event type.
// TESTING
//  1 Two ALU ops writing r3=5 and r4=7, no events -> both regs written next cycle, retire_cnt +2, flush_o=0.
//  2 Both slots write r3 (0x11, 0x22) -> only slot1 write enabled; r3=0x22. Write to r0 -> reg_we_o=0.
//  3 Slot0 exception ecode 0x0B, pc=0x1C000100, eentry=0x1C008000 -> excp_o=1, no writes, slot1 dropped, flush 1 cycle, redirect 0x1C008000, retire_cnt +0.
//  4 Slot0 normal, slot1 ERTN with era=0x1C000200 -> slot0 writes, ertn_o=1, redirect 0x1C000200, retire_cnt +2.
//  5 IDLE at pc=0x1C000300 -> pause_o=1 held 20 cycles; then int_pending_i=1 -> excp_o=1, excp_pc_o=0x1C000304, pause_o=0.
//  6 rst asserted while in IDLE, and separately during FLUSH -> next cycle all outputs 0, state RUN, retire_cnt_o=0.

Source files
------------

// File: rtl/pipeline_types.sv
// Shared types for the retire stage: FSM states, commit events and the
// per-slot request bundle unpacked from the writeback registers.
package pipeline_types;

    localparam int ISSUE_WIDTH = 2;
    localparam int REG_AW      = 5;
    localparam int CSR_AW      = 14;
    localparam int ECODE_W     = 6;
    localparam int SLOT_W      = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

    localparam logic [ECODE_W-1:0] ECODE_INT = '0;

    typedef enum logic [1:0] {
        RUN,
        IDLE,
        FLUSH
    } commit_state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_EXCP,
        EV_ERTN,
        EV_IDLE,
        EV_CSR
    } commit_event_t;

    typedef struct packed {
        logic               valid;
        logic [31:0]        pc;
        logic               reg_we;
        logic [REG_AW-1:0]  reg_waddr;
        logic [31:0]        reg_wdata;
        logic               excp;
        logic [ECODE_W-1:0] ecode;
        logic               ertn;
        logic               idle;
    } commit_req_t;

endpackage

// File: rtl/commit_slot_select.sv
// First-event priority encoder: decides which slots retire and which slot,
// if any, carries the event that ends this retire group.
module commit_slot_select
    import pipeline_types::*;
(
    input  commit_req_t         req [ISSUE_WIDTH],
    input  logic                int_take,
    input  logic                csr_we,
    output logic [ISSUE_WIDTH-1:0] retire,
    output commit_event_t       ev_type,
    output logic [SLOT_W-1:0]   ev_slot,
    output logic [ECODE_W-1:0]  ev_ecode
);

    always_comb begin
        retire   = '0;
        ev_type  = EV_NONE;
        ev_slot  = '0;
        ev_ecode = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (ev_type == EV_NONE && req[i].valid) begin
                // A pending interrupt is taken on slot 0 ahead of its own exception
                if ((i == 0 && int_take) || req[i].excp) begin
                    ev_type  = EV_EXCP;
                    ev_slot  = SLOT_W'(i);
                    ev_ecode = (i == 0 && int_take) ? ECODE_INT : req[i].ecode;
                end else begin
                    retire[i] = 1'b1;
                    if (req[i].ertn) begin
                        ev_type = EV_ERTN;
                        ev_slot = SLOT_W'(i);
                    end else if (req[i].idle) begin
                        ev_type = EV_IDLE;
                        ev_slot = SLOT_W'(i);
                    end else if (i == 0 && csr_we) begin
                        // Refetch from pc0+4, so younger slots must not retire
                        ev_type = EV_CSR;
                        ev_slot = SLOT_W'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_unit.sv
// Retire stage: regfile/CSR commit, exception/ertn/idle handling, flush
// and redirect generation, and the retired-instruction counter.
module commit_unit
    import pipeline_types::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ISSUE_WIDTH-1:0]        wb_valid_i,
    input  logic [ISSUE_WIDTH*32-1:0]     wb_pc_i,
    input  logic [ISSUE_WIDTH-1:0]        wb_reg_we_i,
    input  logic [ISSUE_WIDTH*REG_AW-1:0] wb_reg_waddr_i,
    input  logic [ISSUE_WIDTH*32-1:0]     wb_reg_wdata_i,
    input  logic                          wb_csr_we_i,
    input  logic [CSR_AW-1:0]             wb_csr_waddr_i,
    input  logic [31:0]                   wb_csr_wdata_i,
    input  logic [ISSUE_WIDTH-1:0]        wb_excp_i,
    input  logic [ISSUE_WIDTH*ECODE_W-1:0] wb_ecode_i,
    input  logic [ISSUE_WIDTH-1:0]        wb_ertn_i,
    input  logic [ISSUE_WIDTH-1:0]        wb_idle_i,
    input  logic                          int_pending_i,
    input  logic [31:0]                   csr_eentry_i,
    input  logic [31:0]                   csr_era_i,
    output logic [ISSUE_WIDTH-1:0]        reg_we_o,
    output logic [ISSUE_WIDTH*REG_AW-1:0] reg_waddr_o,
    output logic [ISSUE_WIDTH*32-1:0]     reg_wdata_o,
    output logic                          csr_we_o,
    output logic [CSR_AW-1:0]             csr_waddr_o,
    output logic [31:0]                   csr_wdata_o,
    output logic                          excp_o,
    output logic [ECODE_W-1:0]            excp_ecode_o,
    output logic [31:0]                   excp_pc_o,
    output logic                          ertn_o,
    output logic                          flush_o,
    output logic [31:0]                   redirect_pc_o,
    output logic                          pause_o,
    output logic [63:0]                   retire_cnt_o
);

    commit_state_t          state;
    commit_req_t            req [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] retire;
    logic [ISSUE_WIDTH-1:0] we_raw;
    logic [ISSUE_WIDTH-1:0] we_next;
    commit_event_t          ev_type;
    logic [SLOT_W-1:0]      ev_slot;
    logic [ECODE_W-1:0]     ev_ecode;
    logic [31:0]            idle_pc;
    logic                   int_take;

    assign int_take = int_pending_i && (state == RUN);

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            req[i].valid     = wb_valid_i[i];
            req[i].pc        = wb_pc_i[i*32 +: 32];
            req[i].reg_we    = wb_reg_we_i[i];
            req[i].reg_waddr = wb_reg_waddr_i[i*REG_AW +: REG_AW];
            req[i].reg_wdata = wb_reg_wdata_i[i*32 +: 32];
            req[i].excp      = wb_excp_i[i];
            req[i].ecode     = wb_ecode_i[i*ECODE_W +: ECODE_W];
            req[i].ertn      = wb_ertn_i[i];
            req[i].idle      = wb_idle_i[i];
        end
    end

    commit_slot_select u_select (
        .req      (req),
        .int_take (int_take),
        .csr_we   (wb_csr_we_i),
        .retire   (retire),
        .ev_type  (ev_type),
        .ev_slot  (ev_slot),
        .ev_ecode (ev_ecode)
    );

    // r0 is hardwired; on a same-register pair the younger slot wins
    always_comb begin
        we_raw = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            we_raw[i] = retire[i] && req[i].reg_we && (req[i].reg_waddr != '0);
        end
        we_next = we_raw;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            for (int j = i + 1; j < ISSUE_WIDTH; j++) begin
                if (we_raw[i] && we_raw[j] && req[i].reg_waddr == req[j].reg_waddr) begin
                    we_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            idle_pc       <= '0;
            reg_we_o      <= '0;
            reg_waddr_o   <= '0;
            reg_wdata_o   <= '0;
            csr_we_o      <= 1'b0;
            csr_waddr_o   <= '0;
            csr_wdata_o   <= '0;
            excp_o        <= 1'b0;
            excp_ecode_o  <= '0;
            excp_pc_o     <= '0;
            ertn_o        <= 1'b0;
            flush_o       <= 1'b0;
            redirect_pc_o <= '0;
            pause_o       <= 1'b0;
            retire_cnt_o  <= '0;
        end else begin
            reg_we_o      <= '0;
            reg_waddr_o   <= '0;
            reg_wdata_o   <= '0;
            csr_we_o      <= 1'b0;
            csr_waddr_o   <= '0;
            csr_wdata_o   <= '0;
            excp_o        <= 1'b0;
            excp_ecode_o  <= '0;
            excp_pc_o     <= '0;
            ertn_o        <= 1'b0;
            flush_o       <= 1'b0;
            redirect_pc_o <= '0;
            unique case (state)
                RUN: begin
                    reg_we_o     <= we_next;
                    reg_waddr_o  <= wb_reg_waddr_i;
                    reg_wdata_o  <= wb_reg_wdata_i;
                    csr_we_o     <= wb_csr_we_i && retire[0];
                    csr_waddr_o  <= wb_csr_waddr_i;
                    csr_wdata_o  <= wb_csr_wdata_i;
                    retire_cnt_o <= retire_cnt_o + 64'($countones(retire));
                    unique case (ev_type)
                        EV_EXCP: begin
                            excp_o        <= 1'b1;
                            excp_ecode_o  <= ev_ecode;
                            excp_pc_o     <= req[ev_slot].pc;
                            flush_o       <= 1'b1;
                            redirect_pc_o <= csr_eentry_i;
                            state         <= FLUSH;
                        end
                        EV_ERTN: begin
                            ertn_o        <= 1'b1;
                            flush_o       <= 1'b1;
                            redirect_pc_o <= csr_era_i;
                            state         <= FLUSH;
                        end
                        EV_IDLE: begin
                            pause_o <= 1'b1;
                            idle_pc <= req[ev_slot].pc;
                            state   <= IDLE;
                        end
                        EV_CSR: begin
                            flush_o       <= 1'b1;
                            redirect_pc_o <= req[0].pc + 32'd4;
                            state         <= FLUSH;
                        end
                        default: state <= RUN;
                    endcase
                end
                IDLE: begin
                    if (int_pending_i) begin
                        excp_o        <= 1'b1;
                        excp_ecode_o  <= ECODE_INT;
                        excp_pc_o     <= idle_pc + 32'd4;
                        flush_o       <= 1'b1;
                        redirect_pc_o <= csr_eentry_i;
                        pause_o       <= 1'b0;
                        state         <= FLUSH;
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
